wb_axi4lite_master: RTL and testbench

//  Wishbone pipelined slave to AXI4-Lite master bridge; the reverse direction of the AXI4-Lite-to-WB bridge.

---
 rtl/wb_axi4lite_master.sv | 156 +++++++++++++++
 tb/tb_wb_axi4lite_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi4lite_master.sv
// wb_axi4lite_master: pipelined Wishbone slave bridging single transfers onto an AXI4-Lite master
module wb_axi4lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [31:0]           wb_dat_i,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_stall_o,
   output logic [31:0]           wb_dat_o,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awprot,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   input  logic                  bvalid,
   output logic                  bready,
   input  logic [1:0]            bresp,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp
);
   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, DRAIN} state_t;
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   state_t state, state_d;
   logic [ADDR_WIDTH-1:0] addr, addr_d;
   logic [31:0] wdata_d, dat_d;
   logic [3:0] wstrb_d;
   logic awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d, ack_d, err_d;
   logic abort, abort_d, live, timed_out;
   logic [TW-1:0] timer, timer_d;
   assign awaddr = addr;
   assign araddr = addr;
   assign awprot = 3'b000;
   assign arprot = 3'b000;
   assign wb_stall_o = (state != IDLE) | wb_ack_o | wb_err_o;
   assign live = ~abort & wb_cyc_i;
   assign timed_out = (TIMEOUT > 0) && (timer == TW'(TIMEOUT - 1));
   // next-state and next-output decode; abort remembers a dropped cycle so the response is swallowed
   always_comb begin
      state_d   = state;
      addr_d    = addr;
      wdata_d   = wdata;
      wstrb_d   = wstrb;
      awvalid_d = awvalid;
      wvalid_d  = wvalid;
      arvalid_d = arvalid;
      bready_d  = bready;
      rready_d  = rready;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = wb_dat_o;
      timer_d   = (&timer) ? timer : timer + 1'b1;
      abort_d   = (state != IDLE) & (abort | ~wb_cyc_i);
      case (state)
         IDLE: if (wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o) begin
            addr_d    = wb_adr_i;
            wdata_d   = wb_we_i ? wb_dat_i : wdata;
            wstrb_d   = wb_we_i ? wb_sel_i : wstrb;
            awvalid_d = wb_we_i;
            wvalid_d  = wb_we_i;
            arvalid_d = ~wb_we_i;
            state_d   = wb_we_i ? WRITE : READ;
         end
         WRITE: begin
            awvalid_d = awvalid & ~awready;
            wvalid_d  = wvalid & ~wready;
            if (~awvalid_d & ~wvalid_d) begin
               bready_d = 1'b1;
               timer_d  = '0;
               state_d  = WRESP;
            end
         end
         READ: if (arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            timer_d   = '0;
            state_d   = RRESP;
         end
         WRESP: if (bvalid) begin
            bready_d = 1'b0;
            ack_d    = live & (bresp == 2'b00);
            err_d    = live & (bresp != 2'b00);
            state_d  = IDLE;
         end else if (timed_out) begin
            err_d   = live;
            state_d = DRAIN;
         end
         RRESP: if (rvalid) begin
            rready_d = 1'b0;
            dat_d    = rdata;
            ack_d    = live & (rresp == 2'b00);
            err_d    = live & (rresp != 2'b00);
            state_d  = IDLE;
         end else if (timed_out) begin
            err_d   = live;
            state_d = DRAIN;
         end
         DRAIN: if ((bready & bvalid) | (rready & rvalid)) begin
            bready_d = 1'b0;
            rready_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         addr     <= '0;
         wdata    <= '0;
         wstrb    <= '0;
         awvalid  <= 1'b0;
         wvalid   <= 1'b0;
         arvalid  <= 1'b0;
         bready   <= 1'b0;
         rready   <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         timer    <= '0;
         abort    <= 1'b0;
      end else begin
         state    <= state_d;
         addr     <= addr_d;
         wdata    <= wdata_d;
         wstrb    <= wstrb_d;
         awvalid  <= awvalid_d;
         wvalid   <= wvalid_d;
         arvalid  <= arvalid_d;
         bready   <= bready_d;
         rready   <= rready_d;
         wb_ack_o <= ack_d;
         wb_err_o <= err_d;
         wb_dat_o <= dat_d;
         timer    <= timer_d;
         abort    <= abort_d;
      end
   end
endmodule

// File: tb/tb_wb_axi4lite_master.sv
// tb_wb_axi4lite_master: randomized bench with a delay-programmable AXI4-Lite slave and a timing model
module tb_wb_axi4lite_master;
   localparam int TO = 8;
   logic clk, rst;
   logic wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0] wb_sel;
   logic wb_ack_o, wb_err_o, wb_stall_o;
   logic [31:0] wb_dat_o;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   int checks = 0, errors = 0;
   int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   logic [1:0] cur_bresp = 0, cur_rresp = 0;
   logic [31:0] cur_rdata = 0;
   logic [31:0] log_awaddr = 0, log_wdata = 0, log_araddr = 0;
   logic [3:0] log_wstrb = 0;

   wb_axi4lite_master #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
      .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o), .wb_dat_o(wb_dat_o),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // handshake monitor: counts completed AXI beats and logs the request fields
   always @(posedge clk) begin
      if (rst) begin
         aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      end else begin
         if (awvalid && awready) begin aw_hs++; log_awaddr = awaddr; end
         if (wvalid && wready) begin w_hs++; log_wdata = wdata; log_wstrb = wstrb; end
         if (arvalid && arready) begin ar_hs++; log_araddr = araddr; end
         if (bvalid && bready) b_hs++;
         if (rvalid && rready) r_hs++;
      end
   end

   // slave: each ready comes aw/w/ar_dly cycles after valid, each response b/r_dly cycles after its request
   always @(negedge clk) begin
      if (rst) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         bresp = 0; rresp = 0; rdata = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
         awready = awvalid && aw_wait >= aw_dly; aw_wait = awvalid ? aw_wait + 1 : 0;
         wready  = wvalid && w_wait >= w_dly;    w_wait  = wvalid ? w_wait + 1 : 0;
         arready = arvalid && ar_wait >= ar_dly; ar_wait = arvalid ? ar_wait + 1 : 0;
         if (b_hs < aw_hs && b_hs < w_hs) begin
            bvalid = b_wait >= b_dly; bresp = cur_bresp; b_wait++;
         end else begin
            bvalid = 0; b_wait = 0;
         end
         if (r_hs < ar_hs) begin
            rvalid = r_wait >= r_dly; rresp = cur_rresp; rdata = cur_rdata; r_wait++;
         end else begin
            rvalid = 0; r_wait = 0;
         end
      end
   end

   // cycles from the accepting edge to the visible WB response, from the AXI timing rules
   function automatic int exp_lat(input logic we);
      int d;
      d = we ? 1 + ((aw_dly > w_dly) ? aw_dly : w_dly) : 1 + ar_dly;
      if ((we ? b_dly : r_dly) >= TO) return d + 1 + TO;
      return d + 2 + (we ? b_dly : r_dly);
   endfunction

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int drop_at, output int lat, output int nack,
                       output int nerr, output int nboth, output int bad_stall, output logic [31:0] rd);
      int g = 0;
      @(negedge clk);
      while (wb_stall_o && g < 200) begin @(negedge clk); g++; end
      wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
      @(negedge clk);
      wb_stb = 0;
      lat = -1; nack = 0; nerr = 0; nboth = 0; bad_stall = 0; rd = 0;
      for (int i = 1; i <= 50; i++) begin
         if (i == drop_at) wb_cyc = 0;
         if (wb_ack_o) nack++;
         if (wb_err_o) nerr++;
         if (wb_ack_o && wb_err_o) nboth++;
         if ((wb_ack_o || wb_err_o) && lat < 0) begin lat = i; rd = wb_dat_o; end
         if (!wb_stall_o && (wb_ack_o || wb_err_o || b_hs < aw_hs || b_hs < w_hs || r_hs < ar_hs)) bad_stall++;
         @(negedge clk);
      end
      wb_cyc = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      checks++; if ({awvalid, wvalid, arvalid, bready, rready, wb_ack_o, wb_err_o, wb_stall_o} !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %b exp 00000000", {awvalid, wvalid, arvalid, bready, rready, wb_ack_o, wb_err_o, wb_stall_o}); end
      checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", wb_dat_o); end
      checks++; if ({awprot, arprot} !== 6'h00) begin errors++; $display("FAIL reset_prot got %b exp 000000", {awprot, arprot}); end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_write;
      int lat, na, ne, nb, bs, b0;
      logic [31:0] rd;
      aw_dly = 0; w_dly = 0; b_dly = 0; cur_bresp = 0; b0 = b_hs;
      xfer(1, 32'h10, 32'hCAFEBABE, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat got %0d exp 3", lat); end
      checks++; if (na !== 1 || ne !== 0) begin errors++; $display("FAIL wr_resp got ack %0d err %0d exp 1 0", na, ne); end
      checks++; if (log_awaddr !== 32'h10) begin errors++; $display("FAIL wr_awaddr got %h exp 10", log_awaddr); end
      checks++; if (log_wdata !== 32'hCAFEBABE || log_wstrb !== 4'hF) begin errors++; $display("FAIL wr_wdata got %h/%h exp cafebabe/f", log_wdata, log_wstrb); end
      checks++; if (b_hs - b0 !== 1 || bs !== 0) begin errors++; $display("FAIL wr_b got beats %0d badstall %0d exp 1 0", b_hs - b0, bs); end
   endtask

   task automatic test_read;
      int lat, na, ne, nb, bs;
      logic [31:0] rd;
      ar_dly = 0; r_dly = 0; cur_rresp = 0; cur_rdata = 32'h12345678;
      xfer(0, 32'h24, 32'h0, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rd_lat got %0d exp 3", lat); end
      checks++; if (na !== 1 || ne !== 0) begin errors++; $display("FAIL rd_resp got ack %0d err %0d exp 1 0", na, ne); end
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_data got %h exp 12345678", rd); end
      checks++; if (log_araddr !== 32'h24) begin errors++; $display("FAIL rd_araddr got %h exp 24", log_araddr); end
   endtask

   task automatic test_ordering;
      int lat, na, ne, nb, bs, b0, a0;
      logic [31:0] rd;
      for (int k = 0; k < 2; k++) begin
         aw_dly = k ? 4 : 0; w_dly = k ? 0 : 4; b_dly = 0; cur_bresp = 0; b0 = b_hs; a0 = aw_hs;
         xfer(1, 32'h40 + k, 32'h1111 * (k + 1), 4'h3, -1, lat, na, ne, nb, bs, rd);
         checks++; if (lat !== exp_lat(1)) begin errors++; $display("FAIL order%0d_lat got %0d exp %0d", k, lat, exp_lat(1)); end
         checks++; if (na !== 1 || ne !== 0 || b_hs - b0 !== 1 || aw_hs - a0 !== 1) begin errors++; $display("FAIL order%0d_resp got ack %0d err %0d b %0d aw %0d exp 1 0 1 1", k, na, ne, b_hs - b0, aw_hs - a0); end
      end
      aw_dly = 0; w_dly = 0;
   endtask

   task automatic test_errors;
      int lat, na, ne, nb, bs;
      logic [31:0] rd;
      cur_rresp = 2'b10; cur_rdata = 32'h0BADF00D;
      xfer(0, 32'h80, 32'h0, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (ne !== 1 || na !== 0 || nb !== 0 || lat !== 3) begin errors++; $display("FAIL rd_slverr got err %0d ack %0d both %0d lat %0d exp 1 0 0 3", ne, na, nb, lat); end
      cur_rresp = 0; cur_bresp = 2'b11;
      xfer(1, 32'h84, 32'h5A5A5A5A, 4'h1, -1, lat, na, ne, nb, bs, rd);
      checks++; if (ne !== 1 || na !== 0 || nb !== 0 || lat !== 3) begin errors++; $display("FAIL wr_decerr got err %0d ack %0d both %0d lat %0d exp 1 0 0 3", ne, na, nb, lat); end
      cur_bresp = 0;
   endtask

   task automatic test_timeout;
      int lat, na, ne, nb, bs, b0;
      logic [31:0] rd;
      b_dly = 20; b0 = b_hs;
      xfer(1, 32'hC0, 32'h77777777, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (lat !== 2 + TO || ne !== 1 || na !== 0) begin errors++; $display("FAIL wr_timeout got lat %0d err %0d ack %0d exp %0d 1 0", lat, ne, na, 2 + TO); end
      checks++; if (bs !== 0 || b_hs - b0 !== 1 || wb_stall_o !== 1'b0) begin errors++; $display("FAIL wr_drain got badstall %0d b %0d stall %b exp 0 1 0", bs, b_hs - b0, wb_stall_o); end
      b_dly = 0; cur_rdata = 32'hA1B2C3D4;
      xfer(0, 32'hC4, 32'h0, 4'hF, -1, lat, na, ne, nb, bs, rd);
      r_dly = 20; cur_rdata = 32'hDEADDEAD;
      xfer(0, 32'hC8, 32'h0, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (lat !== 2 + TO || ne !== 1 || na !== 0 || bs !== 0) begin errors++; $display("FAIL rd_timeout got lat %0d err %0d ack %0d badstall %0d exp %0d 1 0 0", lat, ne, na, bs, 2 + TO); end
      checks++; if (wb_dat_o !== 32'hA1B2C3D4) begin errors++; $display("FAIL rd_timeout_dat got %h exp a1b2c3d4", wb_dat_o); end
      r_dly = 0;
   endtask

   task automatic test_back_to_back;
      int acc = 0, acks = 0, bad = 0, last = 0, a0;
      aw_dly = 0; w_dly = 0; b_dly = 0; cur_bresp = 0; a0 = aw_hs;
      @(negedge clk);
      wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 4'hF;
      for (int i = 0; i < 40; i++) begin
         if (wb_ack_o) begin
            acks++;
            if (i - last != 3 || !wb_stall_o) bad++;
         end
         if (!wb_stall_o) begin acc++; last = i; end
         wb_adr = 32'h100 + i * 4; wb_dat = $urandom;
         @(negedge clk);
      end
      wb_stb = 0; wb_cyc = 0;
      checks++; if (acc !== 40 / 4 || acks !== 40 / 4) begin errors++; $display("FAIL b2b_count got acc %0d ack %0d exp %0d %0d", acc, acks, 40 / 4, 40 / 4); end
      checks++; if (bad !== 0 || aw_hs - a0 !== acc) begin errors++; $display("FAIL b2b_timing got bad %0d aw %0d exp 0 %0d", bad, aw_hs - a0, acc); end
   endtask

   task automatic test_cyc_drop;
      int lat, na, ne, nb, bs, r0;
      logic [31:0] rd;
      r_dly = 5; cur_rdata = 32'h99999999; r0 = r_hs;
      xfer(0, 32'h200, 32'h0, 4'hF, 2, lat, na, ne, nb, bs, rd);
      checks++; if (na !== 0 || ne !== 0) begin errors++; $display("FAIL drop_resp got ack %0d err %0d exp 0 0", na, ne); end
      checks++; if (r_hs - r0 !== 1 || bs !== 0 || wb_stall_o !== 1'b0) begin errors++; $display("FAIL drop_axi got r %0d badstall %0d stall %b exp 1 0 0", r_hs - r0, bs, wb_stall_o); end
      r_dly = 0; cur_rdata = 32'h13579BDF;
      xfer(0, 32'h204, 32'h0, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (na !== 1 || rd !== 32'h13579BDF || lat !== 3) begin errors++; $display("FAIL drop_next got ack %0d data %h lat %0d exp 1 13579bdf 3", na, rd, lat); end
   endtask

   task automatic test_random;
      int lat, na, ne, nb, bs;
      logic [31:0] rd, adr, dat, dat_m;
      logic [3:0] sel;
      logic we, to, ok;
      dat_m = wb_dat_o;
      for (int n = 0; n < 24; n++) begin
         we = 1'($urandom_range(0, 1)); adr = $urandom; dat = $urandom; sel = 4'($urandom_range(0, 15));
         aw_dly = $urandom_range(0, 10); w_dly = $urandom_range(0, 10); ar_dly = $urandom_range(0, 10);
         b_dly = $urandom_range(0, 10); r_dly = $urandom_range(0, 10);
         cur_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cur_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cur_rdata = $urandom;
         to = (we ? b_dly : r_dly) >= TO;
         ok = !to && (we ? cur_bresp : cur_rresp) == 2'b00;
         if (!we && !to) dat_m = cur_rdata;
         xfer(we, adr, dat, sel, -1, lat, na, ne, nb, bs, rd);
         checks++; if (lat !== exp_lat(we)) begin errors++; $display("FAIL rnd%0d_lat got %0d exp %0d", n, lat, exp_lat(we)); end
         checks++; if (na !== int'(ok) || ne !== int'(!ok) || nb !== 0) begin errors++; $display("FAIL rnd%0d_resp got ack %0d err %0d both %0d exp %0d %0d 0", n, na, ne, nb, ok, !ok); end
         checks++; if (bs !== 0) begin errors++; $display("FAIL rnd%0d_stall got badstall %0d exp 0", n, bs); end
         checks++; if (wb_dat_o !== dat_m) begin errors++; $display("FAIL rnd%0d_dat got %h exp %h", n, wb_dat_o, dat_m); end
         if (we) begin
            checks++; if (log_awaddr !== adr || log_wdata !== dat || log_wstrb !== sel) begin errors++; $display("FAIL rnd%0d_wreq got %h/%h/%h exp %h/%h/%h", n, log_awaddr, log_wdata, log_wstrb, adr, dat, sel); end
         end else begin
            checks++; if (log_araddr !== adr) begin errors++; $display("FAIL rnd%0d_araddr got %h exp %h", n, log_araddr, adr); end
         end
      end
      aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; cur_bresp = 0; cur_rresp = 0;
   endtask

   task automatic test_reset_mid;
      int lat, na, ne, nb, bs;
      logic [31:0] rd;
      cur_rdata = 32'hA5A5A5A5;
      xfer(0, 32'h300, 32'h0, 4'hF, -1, lat, na, ne, nb, bs, rd);
      b_dly = 30;
      @(negedge clk);
      wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h304; wb_dat = 32'h1; wb_sel = 4'hF;
      @(negedge clk);
      wb_stb = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      checks++; if ({awvalid, wvalid, arvalid, bready, rready, wb_ack_o, wb_err_o, wb_stall_o} !== 8'h00 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL midrst got %b dat %h exp 00000000 0", {awvalid, wvalid, arvalid, bready, rready, wb_ack_o, wb_err_o, wb_stall_o}, wb_dat_o); end
      rst = 0; wb_cyc = 0; b_dly = 0;
      xfer(1, 32'h308, 32'h2, 4'hF, -1, lat, na, ne, nb, bs, rd);
      checks++; if (na !== 1 || ne !== 0 || lat !== 3) begin errors++; $display("FAIL midrst_next got ack %0d err %0d lat %0d exp 1 0 3", na, ne, lat); end
   endtask

   initial begin
      rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat = 0; wb_sel = 0;
      test_reset;
      test_write;
      test_read;
      test_ordering;
      test_errors;
      test_timeout;
      test_back_to_back;
      test_cyc_drop;
      test_random;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
